boot_loader: RTL and testbench

- Upstream feeder for the CPU's bootload port.
- Receives a program image over a UART line (8N1) and writes it byte-by-byte into CPU RAM through WriteToMemory/BootLoadAddress.
- Holds BootLoad high for the whole load, then releases it so the CPU starts executing from address 0.
- Replaces manual switch-based bootloading on the board.

---
 rtl/boot_pkg.sv | 11 +
 rtl/uart_rx.sv | 92 +++++++++
 rtl/boot_loader.sv | 143 ++++++++++++++
 tb/tb_boot_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared state encodings and constants for the UART boot loader
package boot_pkg;

  typedef enum logic [2:0] {IDLE, ARMED, LOAD, FLUSH, FINISH} bootState_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  // cycles the last byte is held on the RAM port before the CPU is released
  localparam int FLUSH_CYCLES = 2;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 2-flop input synchronizer
module uart_rx
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  rxState_t         state, nextState;
  logic             rxMeta, rxSync;
  logic [CNT_W-1:0] clkCnt;
  logic [2:0]       bitIdx;
  logic [7:0]       shiftReg;
  logic             cntClr, shiftEn, frameDone;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      state  <= RX_IDLE;
    end else begin
      rxMeta <= rx;
      rxSync <= rxMeta;
      state  <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    cntClr    = 1'b0;
    shiftEn   = 1'b0;
    frameDone = 1'b0;
    case (state)
      RX_IDLE: begin
        cntClr = 1'b1;
        if (!rxSync) nextState = RX_START;
      end
      RX_START: begin
        // a start bit that is high again at mid-bit was a glitch
        if (clkCnt == HALF_LAST) begin
          cntClr    = 1'b1;
          nextState = rxSync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clkCnt == BIT_LAST) begin
          cntClr  = 1'b1;
          shiftEn = 1'b1;
          if (bitIdx == 3'd7) nextState = RX_STOP;
        end
      end
      RX_STOP: begin
        if (clkCnt == BIT_LAST) begin
          cntClr    = 1'b1;
          frameDone = 1'b1;
          nextState = RX_IDLE;
        end
      end
      default: nextState = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clkCnt   <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      clkCnt   <= cntClr ? '0 : clkCnt + CNT_W'(1);
      if (state != RX_DATA) bitIdx <= '0;
      else if (shiftEn)     bitIdx <= bitIdx + 3'd1;
      if (shiftEn) shiftReg <= {rxSync, shiftReg[7:1]};
      if (frameDone) rx_data <= shiftReg;
      rx_valid <= frameDone;
      rx_ferr  <= frameDone & ~rxSync;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - loads a UART-delivered program image into CPU RAM
module boot_loader
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int IMAGE_BYTES  = 16,
  parameter int ADDR_W       = 4,
  parameter int TIMEOUT_CLKS = 4_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              start,
  output logic [7:0]        WriteToMemory,
  output logic [ADDR_W-1:0] BootLoadAddress,
  output logic              BootLoad,
  output logic              busy,
  output logic              done,
  output logic              load_err,
  output logic              frame_err,
  output logic [ADDR_W:0]   byte_count
);

  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LIMIT  = TMO_W'(TIMEOUT_CLKS);
  localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W + 1)'(IMAGE_BYTES);
  localparam logic [FL_W-1:0]   FLUSH_LAST = FL_W'(FLUSH_CYCLES - 1);

  bootState_t       state, nextState;
  logic [7:0]       rxData;
  logic             rxValid, rxFerr;
  logic [TMO_W-1:0] tmoCnt;
  logic [FL_W-1:0]  flushCnt;
  logic [ADDR_W:0]  countInc;
  logic             armLoad, acceptByte, badByte, timeout, flushDone;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) uRx (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .rx_data (rxData),
    .rx_valid(rxValid),
    .rx_ferr (rxFerr)
  );

  assign countInc = byte_count + (ADDR_W + 1)'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState  = state;
    armLoad    = 1'b0;
    acceptByte = 1'b0;
    badByte    = 1'b0;
    timeout    = 1'b0;
    flushDone  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          armLoad   = 1'b1;
          nextState = ARMED;
        end
      end
      ARMED, LOAD: begin
        // a byte arriving in the expiry cycle takes priority over the timeout
        if (rxValid) begin
          if (rxFerr) begin
            badByte = 1'b1;
          end else begin
            acceptByte = 1'b1;
            nextState  = (countInc == LAST_COUNT) ? FLUSH : LOAD;
          end
        end else if (state == LOAD && tmoCnt == TMO_LIMIT) begin
          timeout   = 1'b1;
          nextState = IDLE;
        end
      end
      FLUSH: begin
        if (flushCnt == FLUSH_LAST) begin
          flushDone = 1'b1;
          nextState = FINISH;
        end
      end
      FINISH:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmoCnt   <= '0;
      flushCnt <= '0;
    end else begin
      if (state != LOAD || rxValid)  tmoCnt <= '0;
      else if (tmoCnt != TMO_LIMIT)  tmoCnt <= tmoCnt + TMO_W'(1);
      flushCnt <= (state == FLUSH) ? flushCnt + FL_W'(1) : '0;
    end
  end

  // BootLoad deliberately stays high after a timeout so a partial image never runs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      WriteToMemory   <= '0;
      BootLoadAddress <= '0;
      BootLoad        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      load_err        <= 1'b0;
      frame_err       <= 1'b0;
      byte_count      <= '0;
    end else begin
      if (armLoad) begin
        BootLoad        <= 1'b1;
        busy            <= 1'b1;
        done            <= 1'b0;
        load_err        <= 1'b0;
        frame_err       <= 1'b0;
        byte_count      <= '0;
        BootLoadAddress <= '0;
      end
      if (acceptByte) begin
        WriteToMemory   <= rxData;
        BootLoadAddress <= byte_count[ADDR_W-1:0];
        byte_count      <= countInc;
      end
      if (badByte) frame_err <= 1'b1;
      if (timeout) begin
        load_err <= 1'b1;
        busy     <= 1'b0;
      end
      if (flushDone) begin
        BootLoad <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - scoreboard bench for boot_loader with a byte-level reference model
module tb_boot_loader;

  localparam int CPB  = 4;
  localparam int NB   = 16;
  localparam int AW   = 4;
  localparam int TMO  = 200;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    WriteToMemory;
  logic [AW-1:0] BootLoadAddress;
  logic          BootLoad, busy, done, load_err, frame_err;
  logic [AW:0]   byte_count;

  boot_loader #(
    .CLKS_PER_BIT(CPB), .IMAGE_BYTES(NB), .ADDR_W(AW), .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .start(start),
    .WriteToMemory(WriteToMemory), .BootLoadAddress(BootLoadAddress),
    .BootLoad(BootLoad), .busy(busy), .done(done), .load_err(load_err),
    .frame_err(frame_err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int addr; int data;} wr_t;
  typedef struct {
    int    due;
    string name;
    int    bl, bsy, dn, lerr, ferr, cnt;
    bit    full;
  } st_t;

  wr_t expQ[$];
  st_t stQ[$];

  int checks = 0;
  int errors = 0;

  // reference model of the loader at the level of whole bytes and loads
  bit mArmed, mBusy, mBoot, mDone, mLerr, mFerr;
  int mCount;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int  prevCount = 0;
  wr_t w;
  st_t s;

  always @(negedge clk) begin
    if (reset) begin
      prevCount = 0;
    end else begin
      if (int'(byte_count) == prevCount + 1) begin
        check("write_expected", (expQ.size() > 0) ? 1 : 0, 1);
        if (expQ.size() > 0) begin
          w = expQ.pop_front();
          check("write_addr", int'(BootLoadAddress), w.addr);
          check("write_data", int'(WriteToMemory), w.data);
          check("write_bootload", int'(BootLoad), 1);
        end
      end
      prevCount = int'(byte_count);
    end
    while (stQ.size() > 0 && stQ[0].due <= cyc) begin
      s = stQ.pop_front();
      check({s.name, "_BootLoad"},   int'(BootLoad),   s.bl);
      check({s.name, "_busy"},       int'(busy),       s.bsy);
      check({s.name, "_done"},       int'(done),       s.dn);
      check({s.name, "_load_err"},   int'(load_err),   s.lerr);
      check({s.name, "_frame_err"},  int'(frame_err),  s.ferr);
      check({s.name, "_byte_count"}, int'(byte_count), s.cnt);
      check({s.name, "_pending_writes"}, expQ.size(), 0);
      if (s.full) begin
        check({s.name, "_WriteToMemory"},   int'(WriteToMemory),   0);
        check({s.name, "_BootLoadAddress"}, int'(BootLoadAddress), 0);
      end
    end
  end

  task automatic pushStatus(input string name, input int due, input int bl, input int bsy,
                            input int dn, input int lerr, input int ferr, input int cnt,
                            input bit full);
    st_t t;
    t.due = due; t.name = name; t.bl = bl; t.bsy = bsy; t.dn = dn;
    t.lerr = lerr; t.ferr = ferr; t.cnt = cnt; t.full = full;
    stQ.push_back(t);
  endtask

  task automatic expectModel(input string name);
    pushStatus(name, cyc, int'(mBoot), int'(mBusy), int'(mDone), int'(mLerr), int'(mFerr),
               mCount, 1'b0);
  endtask

  task automatic modelReset();
    mArmed = 0; mBusy = 0; mBoot = 0; mDone = 0; mLerr = 0; mFerr = 0; mCount = 0;
  endtask

  task automatic pulseStart();
    @(posedge clk); #1 start = 1'b1;
    if (!mBusy) begin
      mArmed = 1; mBusy = 1; mBoot = 1; mDone = 0; mLerr = 0; mFerr = 0; mCount = 0;
    end
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] d, input bit goodStop, input int gap,
                          output int e0);
    if (mArmed && !goodStop) mFerr = 1;
    if (mArmed && goodStop) begin
      wr_t x;
      x.addr = mCount; x.data = int'(d);
      expQ.push_back(x);
      mCount++;
      if (mCount == NB) begin
        mArmed = 0; mBusy = 0; mBoot = 0; mDone = 1;
      end
    end
    @(posedge clk); #1 rx = 1'b0;
    e0 = cyc;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = d[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx = goodStop;
    repeat (CPB) @(posedge clk);
    #1 rx = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic silence(input int n);
    repeat (n) @(posedge clk);
    if (mArmed && mCount > 0) begin
      mLerr = 1; mBusy = 0; mArmed = 0;
    end
  endtask

  task automatic settle(input string name);
    repeat (3) @(posedge clk);
    #1 expectModel(name);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    int e0;
    modelReset();
    repeat (3) @(posedge clk);
    #1 pushStatus("reset", cyc, 0, 0, 0, 0, 0, 0, 1'b1);
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(posedge clk);

    // full image 0x10..0x1F with a second start pulse mid-load
    pulseStart();
    for (int k = 0; k < NB; k++) begin
      sendByte(8'h10 + 8'(k), 1'b1, (k == NB - 1) ? 0 : int'($urandom_range(8, 20)), e0);
      if (k == 7) pulseStart();
    end
    pushStatus("pre_release", e0 + 43, 1, 1, 0, 0, 0, NB, 1'b0);
    pushStatus("release",     e0 + 44, 0, 0, 1, 0, 0, NB, 1'b0);
    repeat (10) @(posedge clk);
    settle("image_done");

    // bad stop bit is discarded, next good byte lands at address 0
    pulseStart();
    sendByte(8'hA5, 1'b0, 10, e0);
    sendByte(8'h3C, 1'b1, 10, e0);
    settle("frame_err_load");
    silence(260);
    settle("frame_err_timeout");

    // partial image then silence
    pulseStart();
    for (int k = 0; k < 5; k++) sendByte(8'($urandom), 1'b1, int'($urandom_range(8, 20)), e0);
    silence(260);
    settle("timeout");

    // glitch on the line and a byte while not armed
    @(posedge clk); #1 rx = 1'b0;
    @(posedge clk); #1 rx = 1'b1;
    repeat (12) @(posedge clk);
    sendByte(8'h55, 1'b1, 12, e0);
    settle("idle_glitch");

    // asynchronous reset in the middle of the eighth frame
    pulseStart();
    for (int k = 0; k < 7; k++) sendByte(8'($urandom), 1'b1, int'($urandom_range(8, 20)), e0);
    settle("seven_bytes");
    @(posedge clk); #1 rx = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    modelReset();
    #1 pushStatus("async_reset", cyc, 0, 0, 0, 0, 0, 0, 1'b1);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);

    // a fresh random image loads normally after the reset
    pulseStart();
    for (int k = 0; k < NB; k++)
      sendByte(8'($urandom), 1'b1, (k == NB - 1) ? 0 : int'($urandom_range(8, 20)), e0);
    pushStatus("reload_pre_release", e0 + 43, 1, 1, 0, 0, 0, NB, 1'b0);
    pushStatus("reload_release",     e0 + 44, 0, 0, 1, 0, 0, NB, 1'b0);
    repeat (10) @(posedge clk);
    settle("reload_done");

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
